// File: rtl/alu_defs.sv
// Shared definitions for the bit-serial ALU and its 1-bit slice.
// Holds the opcode encodings (MIPS funct-style), the FSM state encodings of
// the serial controller, and a helper telling which opcodes subtract.
package alu_defs;

  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_SLT = 6'b101010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // SUB and SLT compute A + ~B + 1: B is inverted in the slice and the
  // carry chain is seeded with 1.
  function automatic logic op_inverts_b(input logic [5:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/ALU_1bit.sv
// One-bit ALU slice.
// Ports:
//   a, b     : operand bits
//   cin      : carry in
//   signal   : 6-bit opcode
//   data_out : result bit (AND/OR bit, or sum bit for ADD/SUB/SLT; 0 otherwise)
//   cout     : carry out of the adder (0 for non-arithmetic opcodes)
module ALU_1bit
  import alu_defs::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [5:0] signal,
  output logic       data_out,
  output logic       cout
);

  logic b_eff;
  logic sum;
  logic carry;

  always_comb begin
    b_eff    = op_inverts_b(signal) ? ~b : b;
    sum      = a ^ b_eff ^ cin;
    carry    = (a & b_eff) | (a & cin) | (b_eff & cin);
    data_out = 1'b0;
    cout     = 1'b0;
    case (signal)
      OP_AND: data_out = a & b;
      OP_OR:  data_out = a | b;
      OP_ADD, OP_SUB, OP_SLT: begin
        data_out = sum;
        cout     = carry;
      end
      default: begin
        data_out = 1'b0;
        cout     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: processes one bit per clock through a single ALU_1bit
// slice, LSB first, taking WIDTH cycles in RUN.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   start   : begin an operation on dataA/dataB/Signal (accepted in IDLE only)
//   dataA   : operand A
//   dataB   : operand B
//   Signal  : opcode (AND, OR, ADD, SUB, SLT)
//   busy    : high in RUN and DONE
//   done    : one-cycle pulse when dataOut carries a new result
//   dataOut : registered result, held between operations
module alu_serial
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [5:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic slice_a;
  logic slice_b;
  logic slice_out;
  logic slice_cout;
  logic slt_bit;

  // Operands are latched and indexed by the bit counter, so changes on
  // dataA/dataB/Signal during RUN cannot disturb the operation.
  assign slice_a = a_q[cnt_q];
  assign slice_b = b_q[cnt_q];

  ALU_1bit u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_q),
    .signal   (op_q),
    .data_out (slice_out),
    .cout     (slice_cout)
  );

  // Signed less-than: sign of A-B corrected by overflow (carry into MSB
  // differs from carry out of MSB). Only meaningful on the MSB cycle.
  assign slt_bit = slice_out ^ (carry_q ^ slice_cout);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    data_out_d = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = dataA;
          b_d     = dataB;
          op_d    = Signal;
          cnt_d   = '0;
          carry_d = op_inverts_b(Signal);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[cnt_q] = slice_out;
        carry_d      = slice_cout;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // The final carry-out is dropped; there is no overflow output.
          carry_d    = 1'b0;
          cnt_d      = '0;
          state_d    = ST_DONE;
          data_out_d = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : res_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      data_out_q <= data_out_d;
    end
  end

  // Working registers are fully rewritten on every accepted start.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    op_q  <= op_d;
    res_q <= res_d;
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign dataOut = data_out_q;

endmodule
